// File: rtl/pc_stack_if.sv
// pc_stack_if: decoder-side bundle for the program-counter sequencer.
//   master : drives stall, pc_op, cond, target; observes pc, sp, tos and flags
//   slave  : the sequencer itself (pc_stack_unit)
// Signals:
//   stall      hold all sequencer state this cycle
//   pc_op      000 INC, 001 JMP, 010 BR, 011 CALL, 100 RET, others INC
//   cond       branch condition for BR
//   target     absolute target (JMP/CALL) or signed offset (BR)
//   pc         current program counter (registered)
//   sp         number of valid return-stack entries, 0..DEPTH
//   tos        top-of-stack return address, 0 when the stack is empty
//   stack_ovf  sticky: CALL seen with the stack full
//   stack_unf  sticky: RET seen with the stack empty
interface pc_stack_if #(
  parameter int n     = 8,
  parameter int DEPTH = 4
);
  localparam int SPW = $clog2(DEPTH + 1);

  logic           stall;
  logic [2:0]     pc_op;
  logic           cond;
  logic [n-1:0]   target;
  logic [n-1:0]   pc;
  logic [SPW-1:0] sp;
  logic [n-1:0]   tos;
  logic           stack_ovf;
  logic           stack_unf;

  modport master (
    output stall, pc_op, cond, target,
    input  pc, sp, tos, stack_ovf, stack_unf
  );

  modport slave (
    input  stall, pc_op, cond, target,
    output pc, sp, tos, stack_ovf, stack_unf
  );
endinterface

// File: rtl/pc_stack_unit.sv
// pc_stack_unit: parametrised program-counter sequencer with relative
// conditional branch and a register-based call/return stack.
// Ports:
//   clk    rising-edge system clock
//   reset  synchronous, active-high; loads RESET_VEC, empties the stack,
//          clears both sticky flags
//   bus    pc_stack_if.slave (see the interface file for signal list)
// All state is registered; pc has no combinational path from the inputs.
module pc_stack_unit #(
  parameter int           n         = 8,
  parameter int           DEPTH     = 4,
  parameter logic [n-1:0] RESET_VEC = '0
) (
  input  logic     clk,
  input  logic     reset,
  pc_stack_if.slave bus
);
  localparam int             SPW      = $clog2(DEPTH + 1);
  localparam logic [SPW-1:0] DEPTH_SP = SPW'(DEPTH);

  typedef enum logic [2:0] {
    OP_INC  = 3'b000,
    OP_JMP  = 3'b001,
    OP_BR   = 3'b010,
    OP_CALL = 3'b011,
    OP_RET  = 3'b100
  } op_e;

  // Modulo-2^n relative add; the offset is two's complement, carries drop.
  function automatic logic [n-1:0] br_add(input logic [n-1:0] base,
                                          input logic signed [n-1:0] off);
    return base + $unsigned(off);
  endfunction

  logic [n-1:0]   pc_p0;
  logic [SPW-1:0] sp_p0;
  logic           ovf_p0;
  logic           unf_p0;
  logic [n-1:0]   mem [DEPTH];

  logic [n-1:0]   pc_inc;
  logic [n-1:0]   tos_c;
  logic [n-1:0]   pc_nx;
  logic [SPW-1:0] sp_nx;
  logic           ovf_nx;
  logic           unf_nx;
  logic           push;

  assign pc_inc = pc_p0 + n'(1);

  // Entries at or above sp are stale; only mem[sp-1] is ever visible.
  always_comb begin
    tos_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sp_p0 == SPW'(i + 1)) tos_c = mem[i];
    end
  end

  always_comb begin
    pc_nx  = pc_inc;
    sp_nx  = sp_p0;
    ovf_nx = ovf_p0;
    unf_nx = unf_p0;
    push   = 1'b0;
    case (op_e'(bus.pc_op))
      OP_JMP: pc_nx = bus.target;
      OP_BR:  if (bus.cond) pc_nx = br_add(pc_p0, bus.target);
      OP_CALL: begin
        // A full stack still takes the jump; only the return is lost.
        pc_nx = bus.target;
        if (sp_p0 < DEPTH_SP) begin
          push  = 1'b1;
          sp_nx = sp_p0 + SPW'(1);
        end else begin
          ovf_nx = 1'b1;
        end
      end
      OP_RET: begin
        if (sp_p0 != '0) begin
          pc_nx = tos_c;
          sp_nx = sp_p0 - SPW'(1);
        end else begin
          unf_nx = 1'b1;
        end
      end
      default: pc_nx = pc_inc;
    endcase
  end

  // Stage p0: architectural state register
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_p0  <= RESET_VEC;
      sp_p0  <= '0;
      ovf_p0 <= 1'b0;
      unf_p0 <= 1'b0;
    end else if (!bus.stall) begin
      pc_p0  <= pc_nx;
      sp_p0  <= sp_nx;
      ovf_p0 <= ovf_nx;
      unf_p0 <= unf_nx;
    end
  end

  // Return addresses are data: written on push, never reset.
  always_ff @(posedge clk) begin
    if (!reset && !bus.stall && push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (sp_p0 == SPW'(i)) mem[i] <= pc_inc;
      end
    end
  end

  assign bus.pc        = pc_p0;
  assign bus.sp        = sp_p0;
  assign bus.tos       = tos_c;
  assign bus.stack_ovf = ovf_p0;
  assign bus.stack_unf = unf_p0;
endmodule

// File: tb/tb_pc_stack_unit.sv
// tb_pc_stack_unit: directed plus randomized checks of pc_stack_unit
// (n=8, DEPTH=4) against a queue-based reference model.
module tb_pc_stack_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_stack_if #(.n(8), .DEPTH(4)) bus ();
  pc_stack_unit #(.n(8), .DEPTH(4), .RESET_VEC(8'h00)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: architectural state only.
  logic [7:0] m_pc;
  logic [7:0] m_stk[$];
  logic       m_ovf;
  logic       m_unf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit rs, input bit st, input logic [2:0] op,
                            input bit c, input logic [7:0] t);
    int off;
    if (rs) begin
      m_pc = 8'h00; m_stk.delete(); m_ovf = 0; m_unf = 0;
    end else if (!st) begin
      case (op)
        3'd1: m_pc = t;
        3'd2: begin
          if (c) begin
            off  = (t >= 8'd128) ? int'(t) - 256 : int'(t);
            m_pc = 8'((((int'(m_pc) + off) % 256) + 256) % 256);
          end else m_pc = m_pc + 8'd1;
        end
        3'd3: begin
          if (m_stk.size() < 4) m_stk.push_back(m_pc + 8'd1);
          else m_ovf = 1;
          m_pc = t;
        end
        3'd4: begin
          if (m_stk.size() > 0) m_pc = m_stk.pop_back();
          else begin m_pc = m_pc + 8'd1; m_unf = 1; end
        end
        default: m_pc = m_pc + 8'd1;
      endcase
    end
  endtask

  // Apply one cycle, advance the model, then compare every output.
  task automatic step(input string tag, input logic [2:0] op, input bit c,
                      input logic [7:0] t, input bit st = 0, input bit rs = 0);
    reset = rs; bus.stall = st; bus.pc_op = op; bus.cond = c; bus.target = t;
    @(posedge clk);
    model_edge(rs, st, op, c, t);
    #1;
    chk({tag, ".pc"},  32'(bus.pc),  32'(m_pc));
    chk({tag, ".sp"},  32'(bus.sp),  32'(m_stk.size()));
    chk({tag, ".tos"}, 32'(bus.tos), (m_stk.size() > 0) ? 32'(m_stk[$]) : 32'd0);
    chk({tag, ".ovf"}, 32'(bus.stack_ovf), 32'(m_ovf));
    chk({tag, ".unf"}, 32'(bus.stack_unf), 32'(m_unf));
  endtask

  initial begin
    logic [2:0] rop;
    m_pc = 8'h00; m_ovf = 0; m_unf = 0;
    reset = 1; bus.stall = 0; bus.pc_op = 3'd0; bus.cond = 0; bus.target = 8'h00;

    // Reset held three cycles with INC on the op lines.
    for (int i = 0; i < 3; i++) begin
      step("rst", 3'd0, 0, 8'h00, 0, 1);
      chk("rst.pc_const", 32'(bus.pc), 32'h00);
    end
    step("inc1", 3'd0, 0, 8'h00); chk("inc1.const", 32'(bus.pc), 32'h01);
    step("inc2", 3'd0, 0, 8'h00); chk("inc2.const", 32'(bus.pc), 32'h02);
    step("inc3", 3'd0, 0, 8'h00);
    step("jmpff", 3'd1, 0, 8'hFF);
    step("wrap", 3'd0, 0, 8'h00); chk("wrap.const", 32'(bus.pc), 32'h00);
    step("op5", 3'd5, 1, 8'h33);
    step("op6", 3'd6, 1, 8'h33);
    step("op7", 3'd7, 1, 8'h33); chk("op7.const", 32'(bus.pc), 32'h03);

    // Jumps and branches.
    step("jmp40", 3'd1, 0, 8'h40); chk("jmp40.const", 32'(bus.pc), 32'h40);
    step("br_t",  3'd2, 1, 8'hFE); chk("br_t.const",  32'(bus.pc), 32'h3E);
    step("br_f",  3'd2, 0, 8'hFE); chk("br_f.const",  32'(bus.pc), 32'h3F);
    step("jmpfd", 3'd1, 0, 8'hFD);
    step("br_w",  3'd2, 1, 8'h05); chk("br_w.const",  32'(bus.pc), 32'h02);

    // Single call/return.
    step("jmp10", 3'd1, 0, 8'h10);
    step("call",  3'd3, 0, 8'h80); chk("call.tos_const", 32'(bus.tos), 32'h11);
    step("ret",   3'd4, 0, 8'h00); chk("ret.pc_const",   32'(bus.pc),  32'h11);

    // Nested calls to overflow, then returns to underflow.
    step("jmp10b", 3'd1, 0, 8'h10);
    step("c1", 3'd3, 0, 8'h20);
    step("c2", 3'd3, 0, 8'h30);
    step("c3", 3'd3, 0, 8'h40);
    step("c4", 3'd3, 0, 8'h50); chk("c4.tos_const", 32'(bus.tos), 32'h41);
    step("c5", 3'd3, 0, 8'h90); chk("c5.ovf_const", 32'(bus.stack_ovf), 32'd1);
    step("r1", 3'd4, 0, 8'h00); chk("r1.const", 32'(bus.pc), 32'h41);
    step("r2", 3'd4, 0, 8'h00); chk("r2.const", 32'(bus.pc), 32'h31);
    step("r3", 3'd4, 0, 8'h00); chk("r3.const", 32'(bus.pc), 32'h21);
    step("r4", 3'd4, 0, 8'h00); chk("r4.const", 32'(bus.pc), 32'h11);
    step("r5", 3'd4, 0, 8'h00); chk("r5.const", 32'(bus.pc), 32'h12);
    chk("r5.unf_const", 32'(bus.stack_unf), 32'd1);
    step("okcall", 3'd3, 0, 8'h60); chk("sticky.ovf", 32'(bus.stack_ovf), 32'd1);

    // Stall with sp=3, then reset colliding with RET.
    step("rst2", 3'd0, 0, 8'h00, 0, 1);
    step("s1", 3'd3, 0, 8'hA0);
    step("s2", 3'd3, 0, 8'hB0);
    step("s3", 3'd3, 0, 8'hC0); chk("s3.sp_const", 32'(bus.sp), 32'd3);
    step("stall1", 3'd3, 0, 8'hD0, 1, 0);
    step("stall2", 3'd3, 0, 8'hD0, 1, 0);
    chk("stall.pc_const", 32'(bus.pc), 32'hC0);
    chk("stall.tos_const", 32'(bus.tos), 32'hB1);
    step("rstret", 3'd4, 0, 8'h00, 0, 1);
    chk("rstret.pc_const", 32'(bus.pc), 32'h00);
    chk("rstret.sp_const", 32'(bus.sp), 32'd0);

    // Randomized traffic, biased toward stack ops.
    for (int i = 0; i < 400; i++) begin
      rop = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) rop = ($urandom_range(0, 1) != 0) ? 3'd3 : 3'd4;
      step("rand", rop, 1'($urandom_range(0, 1)), 8'($urandom),
           $urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
- Parametrised program-counter sequencer for the RISC CPU, the next generation of the fixed-width PC.
- Adds generic width `n`, relative conditional branch, and a hardware call/return stack of configurable depth.
- Sits between the decoder (supplies `pc_op`, `cond`, `target`) and instruction memory (consumes `pc`).
- Sticky overflow/underflow flags expose stack misuse to the testbench and to future trap logic.

Parameters:
- n, 8, PC/address width in bits.
- DEPTH, 4, return-stack entries (DEPTH >= 1).
- RESET_VEC, 0, PC value loaded on reset (n bits).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  1 = hold all state this cycle.
- pc_op  in  3  000 INC, 001 JMP, 010 BR, 011 CALL, 100 RET, 101-111 treated as INC.
- cond  in  1  branch condition for BR.
- target  in  n  absolute target (JMP/CALL) or two's-complement offset (BR).
- pc  out  n  current program counter (registered).
- sp  out  $clog2(DEPTH+1)  number of valid stack entries, 0..DEPTH.
- tos  out  n  top-of-stack return address; 0 when sp==0.
- stack_ovf  out  1  sticky: CALL attempted with stack full.
- stack_unf  out  1  sticky: RET attempted with stack empty.

Behaviour:
- One clock; reset is synchronous and active-high. All state updates on rising clk edge.
- Priority per edge: reset > stall > pc_op.
- Reset: pc<=RESET_VEC, sp<=0, stack_ovf<=0, stack_unf<=0; tos reads 0. Stack RAM contents are don't-care.
  - Reset asserted mid-sequence (any sp, any op) takes effect on that edge; op is ignored.
- Latency: pc_op/cond/target sampled at edge k; the new pc is visible after edge k. No combinational path from inputs to pc.
- stall=1: pc, sp, stack contents and flags all hold; op is discarded, not queued.
- All PC arithmetic is modulo 2^n; carries are dropped.
- INC: pc<=pc+1 (0xFF -> 0x00 for n=8).
- JMP: pc<=target.
- BR:
  - cond=1: pc<=pc+target, with target interpreted as signed n-bit.
  - cond=0: pc<=pc+1.
- CALL:
  - sp<DEPTH: mem[sp]<=pc+1 (wrapped), sp<=sp+1, pc<=target.
  - sp==DEPTH: pc<=target, stack and sp unchanged, stack_ovf<=1.
- RET:
  - sp>0: pc<=mem[sp-1], sp<=sp-1.
  - sp==0: pc<=pc+1, stack_unf<=1.
- tos = mem[sp-1] when sp>0, else 0. It is a combinational read of registered state, so it is stable all cycle.
- Flags are sticky: they clear only on reset and never on a later successful op.
- Undefined opcodes 101-111 behave exactly as INC and do not set any flag.
- Stack is register-based (DEPTH small). There is no simultaneous push/pop case, since one op executes per cycle.

Test Plan:
- Defaults n=8, DEPTH=4 throughout.
- Reset and INC: hold reset 3 cycles, then INC continuously -> pc=0x00 during reset, 0x01 after the first released edge, increments each cycle; from pc=0xFF, INC -> 0x00, flags stay 0.
- JMP and BR: JMP target=0x40 -> pc=0x40; BR cond=1 target=0xFE -> pc=0x3E; BR cond=0 target=0xFE -> pc=0x3F; BR cond=1 target=0x05 at pc=0xFD -> pc=0x02 (wrap).
- CALL and RET: at pc=0x10, CALL target=0x80 -> pc=0x80, sp=1, tos=0x11; RET -> pc=0x11, sp=0, tos=0.
- Overflow and underflow:
  - Four nested CALLs from pc 0x10/0x20/0x30/0x40 -> sp=4, tos=0x41.
  - Fifth CALL target=0x90 -> pc=0x90, sp=4, stack_ovf=1.
  - Four RETs -> pc 0x41, 0x31, 0x21, 0x11 in order.
  - Fifth RET -> pc=0x12, stack_unf=1; stack_ovf still 1.
- Stall and reset mid-operation: with sp=3, assert stall with CALL for 2 cycles -> pc, sp, tos unchanged. Release stall and assert reset with RET on the same edge -> pc=0x00, sp=0, both flags 0 after that edge.
